// File: rtl/segment_sequencer_if.sv
// Host/feeder-side bundle for segment_sequencer: queue writes, sequence control and bank handshake.
// The loop input exists only when SEQ_LOOP_EN is defined.
interface segment_sequencer_if #(
  parameter int TIME_W = 16,
  parameter int IDX_W  = 4
);
  logic [TIME_W-1:0] seg_time;
  logic              seg_wr;
  logic              seg_full;
  logic [IDX_W:0]    seg_count;
  logic              start;
  logic              abort;
  logic              bank_ready;
  logic              bank_swap;
  logic              dds_reset;
  logic              sample_en;
  logic [IDX_W-1:0]  seg_idx;
  logic              busy;
  logic              seq_done;
  logic              underrun;
`ifdef SEQ_LOOP_EN
  logic              loop;
`endif

  modport master (
`ifdef SEQ_LOOP_EN
    output loop,
`endif
    output seg_time, seg_wr, start, abort, bank_ready,
    input  seg_full, seg_count, bank_swap, dds_reset, sample_en,
    input  seg_idx, busy, seq_done, underrun
  );

  modport slave (
`ifdef SEQ_LOOP_EN
    input  loop,
`endif
    input  seg_time, seg_wr, start, abort, bank_ready,
    output seg_full, seg_count, bank_swap, dds_reset, sample_en,
    output seg_idx, busy, seq_done, underrun
  );
endinterface

// File: rtl/segment_sequencer.sv
// Segment time-base controller: duration queue plus FSM driving bank swap, DDS reset and sample enable.
// Optional SEQ_LOOP_EN: with loop=1 while busy, popped durations recirculate to the queue tail.
module segment_sequencer #(
  parameter int DEPTH  = 16,
  parameter int TIME_W = 16,
  parameter int IDX_W  = 4
) (
  input logic clk,
  input logic reset,
  segment_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BANK,
    SWAP,
    RUN,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [TIME_W-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [IDX_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [IDX_W:0]    count_q, count_d;
  logic [TIME_W-1:0] timer_q, timer_d;
  logic [IDX_W-1:0]  seg_idx_q, seg_idx_d;
  logic              underrun_q, underrun_d;

  logic              seg_full;
  logic              loop_busy;
  logic              pop;
  logic              host_push;
  logic              recirc;
  logic              wr_en;
  logic [TIME_W-1:0] wr_data;
  logic [TIME_W-1:0] head;

  assign seg_full = (count_q == (IDX_W+1)'(DEPTH));
  assign head     = mem_q[rd_ptr_q];

`ifdef SEQ_LOOP_EN
  assign loop_busy = bus.loop && (state_q != IDLE);
`else
  assign loop_busy = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    seg_idx_d  = seg_idx_q;
    underrun_d = underrun_q;
    pop        = 1'b0;
    host_push  = bus.seg_wr && !seg_full && !loop_busy;

    unique case (state_q)
      IDLE: begin
        if (bus.start && (count_q != '0)) begin
          state_d    = WAIT_BANK;
          seg_idx_d  = '0;
          underrun_d = 1'b0;
        end
      end
      WAIT_BANK: begin
        if (bus.bank_ready) state_d = SWAP;
      end
      SWAP: begin
        pop     = 1'b1;
        timer_d = (head == '0) ? TIME_W'(1) : head;
        state_d = RUN;
      end
      RUN: begin
        if (timer_q == TIME_W'(1)) begin
          seg_idx_d = seg_idx_q + IDX_W'(1);
          if (count_q == '0) begin
            state_d = DONE;
          end else if (bus.bank_ready) begin
            state_d = SWAP;
          end else begin
            state_d    = WAIT_BANK;
            underrun_d = 1'b1;
          end
        end else begin
          timer_d = timer_q - TIME_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Recirculation reuses the single write port; host writes are locked out while it is possible.
    recirc  = pop && loop_busy;
    wr_en   = host_push || recirc;
    wr_data = recirc ? head : bus.seg_time;

    wr_ptr_d = wr_en ? (wr_ptr_q + IDX_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop   ? (rd_ptr_q + IDX_W'(1)) : rd_ptr_q;
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + (IDX_W+1)'(1);
      2'b01:   count_d = count_q - (IDX_W+1)'(1);
      default: count_d = count_q;
    endcase

    if (bus.abort) begin
      state_d    = IDLE;
      wr_en      = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      seg_idx_d  = seg_idx_q;
      underrun_d = underrun_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      timer_q    <= '0;
      seg_idx_q  <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      seg_idx_q  <= seg_idx_d;
      underrun_q <= underrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem_q[wr_ptr_q] <= wr_data;
  end

  assign bus.seg_full  = seg_full;
  assign bus.seg_count = count_q;
  assign bus.bank_swap = (state_q == SWAP);
  assign bus.dds_reset = (state_q == SWAP);
  assign bus.sample_en = (state_q == RUN);
  assign bus.busy      = (state_q != IDLE);
  assign bus.seq_done  = (state_q == DONE);
  assign bus.seg_idx   = seg_idx_q;
  assign bus.underrun  = underrun_q;

endmodule

// File: tb/tb_segment_sequencer.sv
// Self-checking bench for segment_sequencer: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based behavioural model.
module tb_segment_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  segment_sequencer_if #(.TIME_W(16), .IDX_W(4)) bus ();

  segment_sequencer #(.DEPTH(16), .TIME_W(16), .IDX_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  bit started  = 1'b0;

  // Observed-event tallies used by the directed scenarios.
  int n_sample = 0;
  int n_swap   = 0;
  int n_done   = 0;

  // Behavioural model: queue of durations plus a description of what is happening this cycle.
  int q[$];
  bit m_busy = 0, m_wait = 0, m_swap = 0, m_done = 0, m_und = 0;
  int m_left = 0;
  int m_idx  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    bit lp, was_empty, host_ok;
    int d;
    lp = 1'b0;
`ifdef SEQ_LOOP_EN
    lp = bus.loop && m_busy;
`endif
    started = 1'b1;
    if (reset) begin
      q.delete();
      m_busy = 0; m_wait = 0; m_swap = 0; m_done = 0; m_und = 0;
      m_left = 0; m_idx = 0;
    end else if (bus.abort) begin
      q.delete();
      m_busy = 0; m_wait = 0; m_swap = 0; m_done = 0; m_left = 0;
    end else begin
      host_ok   = bus.seg_wr && (q.size() < 16) && !lp;
      was_empty = (q.size() == 0);
      if (m_swap) begin
        d = q.pop_front();
        if (lp) q.push_back(d);
        m_left = (d == 0) ? 1 : d;
        m_swap = 0;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_idx = (m_idx + 1) % 16;
          if (was_empty) m_done = 1;
          else if (bus.bank_ready) m_swap = 1;
          else begin m_wait = 1; m_und = 1; end
        end
      end else if (m_wait) begin
        if (bus.bank_ready) begin m_wait = 0; m_swap = 1; end
      end else if (m_done) begin
        m_done = 0; m_busy = 0;
      end else if (bus.start && !was_empty) begin
        m_busy = 1; m_wait = 1; m_idx = 0; m_und = 0;
      end
      if (host_ok) q.push_back(int'(bus.seg_time));
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("seg_count", 32'(bus.seg_count), q.size());
      chk("seg_full",  32'(bus.seg_full),  32'(q.size() == 16));
      chk("busy",      32'(bus.busy),      32'(m_busy));
      chk("sample_en", 32'(bus.sample_en), 32'(m_left > 0));
      chk("bank_swap", 32'(bus.bank_swap), 32'(m_swap));
      chk("dds_reset", 32'(bus.dds_reset), 32'(m_swap));
      chk("seq_done",  32'(bus.seq_done),  32'(m_done));
      chk("seg_idx",   32'(bus.seg_idx),   m_idx);
      chk("underrun",  32'(bus.underrun),  32'(m_und));
      if (bus.sample_en) n_sample++;
      if (bus.bank_swap) n_swap++;
      if (bus.seq_done)  n_done++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_tally();
    n_sample = 0; n_swap = 0; n_done = 0;
  endtask

  task automatic push(input int t);
    bus.seg_wr = 1'b1; bus.seg_time = 16'(t);
    tick();
    bus.seg_wr = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!m_busy) return;
    end
    chk("idle_timeout", 32'(m_busy), 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.seg_time = '0; bus.seg_wr = 1'b0; bus.start = 1'b0;
    bus.abort = 1'b0; bus.bank_ready = 1'b0;
`ifdef SEQ_LOOP_EN
    bus.loop = 1'b0;
`endif

    // Reset with random inputs.
    for (int i = 0; i < 2; i++) begin
      bus.seg_time = 16'($urandom); bus.seg_wr = 1'($urandom);
      bus.start = 1'($urandom); bus.abort = 1'($urandom); bus.bank_ready = 1'($urandom);
      tick();
    end
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_count", 32'(bus.seg_count), 0);
    chk("rst_sample_en", 32'(bus.sample_en), 0);
    chk("rst_underrun", 32'(bus.underrun), 0);
    reset = 1'b0;
    bus.seg_wr = 1'b0; bus.start = 1'b0; bus.abort = 1'b0; bus.bank_ready = 1'b0;
    tick();

    // Two back-to-back segments, bank always ready.
    push(3); push(5);
    bus.bank_ready = 1'b1;
    clear_tally();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    wait_idle(100);
    chk("t2_samples", n_sample, 8);
    chk("t2_swaps", n_swap, 2);
    chk("t2_done", n_done, 1);
    chk("t2_seg_idx", 32'(bus.seg_idx), 2);
    chk("t2_underrun", 32'(bus.underrun), 0);

    // Underrun: bank_ready drops after the first swap and returns 6 cycles later.
    push(4); push(4);
    clear_tally();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    tick();
    tick(); bus.bank_ready = 1'b0;
    repeat (6) tick();
    chk("t3_underrun_mid", 32'(bus.underrun), 1);
    chk("t3_stalled", 32'(bus.sample_en), 0);
    bus.bank_ready = 1'b1;
    wait_idle(100);
    chk("t3_samples", n_sample, 8);
    chk("t3_swaps", n_swap, 2);
    chk("t3_underrun_end", 32'(bus.underrun), 1);

    // Overfill, then a write coincident with the first pop.
    bus.seg_wr = 1'b1; bus.seg_time = 16'd1;
    repeat (17) tick();
    bus.seg_wr = 1'b0;
    chk("t4_full", 32'(bus.seg_full), 1);
    chk("t4_count16", 32'(bus.seg_count), 16);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    tick(); bus.seg_wr = 1'b1;
    tick(); bus.seg_wr = 1'b0;
    chk("t4_count15", 32'(bus.seg_count), 15);
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
    chk("t4_flushed", 32'(bus.seg_count), 0);

    // Zero duration runs as one cycle.
    push(0);
    clear_tally();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    wait_idle(50);
    chk("t5_samples", n_sample, 1);
    chk("t5_done", n_done, 1);

    // Abort on the 4th RUN cycle.
    push(10); push(10);
    clear_tally();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    repeat (5) tick();
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
    chk("t6_busy", 32'(bus.busy), 0);
    chk("t6_sample_en", 32'(bus.sample_en), 0);
    chk("t6_count", 32'(bus.seg_count), 0);
    chk("t6_samples", n_sample, 4);
    chk("t6_no_done", n_done, 0);

`ifdef SEQ_LOOP_EN
    // Recirculating 2,3 for three laps.
    push(2); push(3);
    bus.loop = 1'b1;
    clear_tally();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    repeat (21) tick();
    chk("loop_swaps", n_swap, 6);
    chk("loop_samples", n_sample, 15);
    chk("loop_count", 32'(bus.seg_count), 2);
    chk("loop_no_done", n_done, 0);
    bus.loop = 1'b0;
    wait_idle(100);
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bus.seg_wr     = ($urandom_range(0, 99) < 30);
      bus.seg_time   = 16'($urandom_range(0, 6));
      bus.start      = ($urandom_range(0, 99) < 10);
      bus.bank_ready = ($urandom_range(0, 99) < 60);
      bus.abort      = ($urandom_range(0, 999) < 15);
      reset          = ($urandom_range(0, 999) < 4);
`ifdef SEQ_LOOP_EN
      if ($urandom_range(0, 49) == 0) bus.loop = 1'($urandom);
`endif
      tick();
    end
    reset = 1'b0; bus.seg_wr = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
    bus.bank_ready = 1'b1;
`ifdef SEQ_LOOP_EN
    bus.loop = 1'b0;
`endif
    wait_idle(400);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/segment_sequencer.md
Name: segment_sequencer

Overview:
Time-base controller for the 64-channel DDS datapath. It holds a queue of segment durations and, per segment, commands the active-parameter bank swap, the DDS accumulator reset, and the output-FIFO write enable. It replaces the ad-hoc countdown/switch logic in the top level. Runs entirely in the synthesis clock domain; host-side writes arrive already synchronized.

Parameters:
DEPTH, 16, number of duration entries in the segment queue (power of 2)
TIME_W, 16, width of one segment duration in clk cycles
IDX_W, 4, log2(DEPTH); width of pointers and seg_idx

Ports:
clk  input  1  synthesis clock
reset  input  1  synchronous, active-high reset
seg_time  input  TIME_W  duration of the segment being queued
seg_wr  input  1  push seg_time into the queue (ignored while seg_full)
seg_full  output  1  queue holds DEPTH entries
seg_count  output  IDX_W+1  entries currently queued
start  input  1  begin sequence (sampled only in IDLE)
abort  input  1  stop sequence, flush queue
bank_ready  input  1  level: next amp/offset/phaseword bank fully loaded
bank_swap  output  1  1-cycle pulse: latch pre-bank into active registers (also the ack of bank_ready)
dds_reset  output  1  1-cycle pulse coincident with bank_swap
sample_en  output  1  FIFO write enable; high while a segment is running
seg_idx  output  IDX_W  segments completed in the current sequence, wraps
busy  output  1  state != IDLE
seq_done  output  1  1-cycle pulse when the last queued segment ends
underrun  output  1  sticky: a segment ended with more queued but bank_ready low

Behaviour:
- Reset: all outputs 0, queue empty (seg_count 0), pointers 0, state IDLE.
- Queue: circular buffer. seg_wr with !seg_full writes at wr_ptr. seg_wr while seg_full is ignored, even if a pop occurs in the same cycle. Simultaneous accepted push and pop leave seg_count unchanged. seg_full is derived combinationally from the registered count.
- FSM:
  IDLE: start && seg_count>0 -> WAIT_BANK. Clears seg_idx and underrun. start with an empty queue is ignored.
  WAIT_BANK: sample_en=0. bank_ready -> SWAP. Waits indefinitely.
  SWAP: exactly one cycle. bank_swap=1, dds_reset=1, queue head popped into timer (duration 0 loaded as 1) -> RUN.
  RUN: sample_en=1; timer decrements each cycle; a segment of duration T yields exactly T sample_en cycles.
  On the last RUN cycle: seg_idx++. Then:
    queue empty -> DONE.
    queue non-empty and bank_ready=1 -> SWAP. Gap of exactly 1 cycle with sample_en low.
    queue non-empty and bank_ready=0 -> WAIT_BANK, underrun<=1.
  DONE: seq_done=1 for one cycle -> IDLE.
- bank_ready is sampled only in WAIT_BANK and on the last RUN cycle. The feeder must drop it the cycle after bank_swap, before reloading.
- abort (priority below reset, above everything else): next cycle state=IDLE, queue flushed, all pulses/sample_en 0. seg_idx and underrun are held. A seg_wr coincident with abort is dropped.
- start while busy is ignored.

Optional Feature:
SEQ_LOOP_EN: adds input port loop (1 bit).
- With the macro defined and loop=1 while busy, each SWAP pop re-writes the popped duration at the tail. The queue recirculates and never drains, seq_done never fires, and the sequence ends only on abort or loop=0.
- Host seg_wr is ignored while loop=1 and busy.
- Without the macro: no loop port; popped entries are discarded.

Test Plan:
1. Assert reset 2 cycles with random inputs -> all outputs 0, seg_count 0, busy 0.
2. Push 3 then 5, bank_ready held 1, pulse start -> bank_swap/dds_reset at t, sample_en high 3 cycles, 1-cycle gap with bank_swap, sample_en high 5 cycles, seq_done once, seg_idx=2, underrun=0.
3. Push 4,4; bank_ready drops after first bank_swap and re-raises 6 cycles later -> underrun=1 at end of seg 0, sample_en low until bank_ready returns, second swap then 4 sample cycles.
4. DEPTH=16: push 17 entries -> seg_full after 16th, 17th dropped, seg_count=16. One pop plus seg_wr in the same cycle -> write dropped, seg_count=15.
5. Push seg_time=0 and start -> exactly 1 sample_en cycle, then seq_done.
6. Push 10,10, start, abort on the 4th RUN cycle -> next cycle IDLE, sample_en 0, seg_count 0, no seq_done. With SEQ_LOOP_EN and loop=1: durations 2,3 repeat for 3 laps and seg_count stays 2.
